// File: rtl/ds_sequencer.sv
// ds_sequencer: run sequencer sharing the data memory between host load, processor run and result dump
module ds_sequencer #(
  parameter int IN_WORDS  = 65536,
  parameter int OUT_BASE  = 65536,
  parameter int OUT_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        proc_start,
  input  logic        proc_status,
  input  logic [1:0]  proc_mem,
  input  logic [18:0] proc_addr,
  input  logic [7:0]  proc_wdata,
  output logic [7:0]  proc_rdata,
  output logic [18:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        proc_viol
);
  localparam logic [18:0] LAST_IN  = 19'(IN_WORDS - 1);
  localparam logic [18:0] LAST_OUT = 19'(OUT_WORDS - 1);
  localparam logic [18:0] BASE     = 19'(OUT_BASE);
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN, DUMP_RD, DUMP_TX, DONE} state_t;
  state_t state, state_nx;
  logic [18:0] cnt, cnt_nx;
  logic viol_nx, load, run, dump;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      proc_viol <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      proc_viol <= viol_nx;
    end
  end
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    viol_nx  = proc_viol | (state != RUN && (proc_mem == 2'b01 || proc_mem == 2'b10));
    case (state)
      IDLE, DONE: if (host_start) begin
        state_nx = LOAD;
        cnt_nx   = '0;
        viol_nx  = 1'b0;
      end
      LOAD: if (rx_valid) begin
        cnt_nx   = cnt + 19'd1;
        state_nx = cnt == LAST_IN ? START : LOAD;
      end
      START:   state_nx = RUN;
      RUN: if (proc_status) begin
        state_nx = DUMP_RD;
        cnt_nx   = '0;
      end
      DUMP_RD: state_nx = DUMP_TX;
      DUMP_TX: if (tx_ready) begin
        state_nx = cnt == LAST_OUT ? DONE : DUMP_RD;
        cnt_nx   = cnt == LAST_OUT ? cnt : cnt + 19'd1;
      end
      default: state_nx = IDLE;
    endcase
  end
  assign load       = state == LOAD;
  assign run        = state == RUN;
  assign dump       = state == DUMP_RD || state == DUMP_TX;
  assign mem_addr   = run ? proc_addr : load ? cnt : dump ? BASE + cnt : '0;
  assign mem_wdata  = run ? proc_wdata : load ? rx_data : '0;
  assign mem_we     = run ? proc_mem == 2'b10 : load & rx_valid;
  assign tx_valid   = state == DUMP_TX;
  assign tx_data    = tx_valid ? mem_rdata : '0;
  assign proc_start = state == START;
  assign proc_rdata = mem_rdata;
  assign busy       = state != IDLE && state != DONE;
  assign done       = state == DONE;
endmodule

// File: tb/tb_ds_sequencer.sv
// tb_ds_sequencer: table-driven and directed checks of ds_sequencer with a small memory model
module tb_ds_sequencer;
  logic clk = 0, rst_n = 0;
  logic host_start = 0, rx_valid = 0, tx_ready = 0, proc_status = 0;
  logic [7:0] rx_data = 0, proc_wdata = 0, mem_rdata = 0;
  logic [1:0] proc_mem = 0;
  logic [18:0] proc_addr = 0;
  logic tx_valid, proc_start, mem_we, busy, done, proc_viol;
  logic [7:0] tx_data, proc_rdata, mem_wdata;
  logic [18:0] mem_addr;
  logic [7:0] mem [0:31];
  int nwr = 0, nvec = 0, nfail = 0, n0;
  always #5 clk = ~clk;
  ds_sequencer #(.IN_WORDS(4), .OUT_BASE(8), .OUT_WORDS(2)) dut (
    .clk(clk), .rst_n(rst_n), .host_start(host_start), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data), .proc_start(proc_start),
    .proc_status(proc_status), .proc_mem(proc_mem), .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_rdata(proc_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .proc_viol(proc_viol)
  );
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[4:0]] <= mem_wdata;
      nwr <= nwr + 1;
    end
    mem_rdata <= mem[mem_addr[4:0]];
  end
  typedef struct {
    logic hs, rv; logic [7:0] rd; logic tr; logic [1:0] pm; logic [18:0] pa; logic [7:0] pw; logic ps;
    logic e_busy, e_done, e_pst, e_txv; logic [7:0] e_txd; logic e_we; logic [18:0] e_addr; logic e_viol;
  } vec_t;
  vec_t tv [20];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    nvec++;
    if (a !== e) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic idle_in();
    host_start = 0; rx_valid = 0; rx_data = 0; tx_ready = 0;
    proc_mem = 0; proc_addr = 0; proc_wdata = 0; proc_status = 0;
  endtask
  initial begin
    tv[0]  = '{0,0,8'h00,0,2'd0,19'd0,8'h00,0, 0,0,0,0,8'h00,0,19'd0,0};
    tv[1]  = '{1,0,8'h00,0,2'd0,19'd0,8'h00,0, 0,0,0,0,8'h00,0,19'd0,0};
    tv[2]  = '{0,1,8'h11,0,2'd0,19'd0,8'h00,0, 1,0,0,0,8'h00,1,19'd0,0};
    tv[3]  = '{0,1,8'h22,0,2'd0,19'd0,8'h00,0, 1,0,0,0,8'h00,1,19'd1,0};
    tv[4]  = '{0,1,8'h33,0,2'd0,19'd0,8'h00,0, 1,0,0,0,8'h00,1,19'd2,0};
    tv[5]  = '{0,1,8'h44,0,2'd0,19'd0,8'h00,0, 1,0,0,0,8'h00,1,19'd3,0};
    tv[6]  = '{0,0,8'h00,0,2'd0,19'd0,8'h00,0, 1,0,1,0,8'h00,0,19'd0,0};
    tv[7]  = '{0,0,8'h00,0,2'd2,19'd8,8'hA5,0, 1,0,0,0,8'h00,1,19'd8,0};
    tv[8]  = '{0,0,8'h00,0,2'd2,19'd9,8'h5A,0, 1,0,0,0,8'h00,1,19'd9,0};
    tv[9]  = '{0,0,8'h00,0,2'd1,19'd2,8'h00,0, 1,0,0,0,8'h00,0,19'd2,0};
    tv[10] = '{0,0,8'h00,0,2'd0,19'd0,8'h00,1, 1,0,0,0,8'h00,0,19'd0,0};
    tv[11] = '{0,0,8'h00,0,2'd0,19'd0,8'h00,0, 1,0,0,0,8'h00,0,19'd8,0};
    tv[12] = '{0,0,8'h00,1,2'd0,19'd0,8'h00,0, 1,0,0,1,8'hA5,0,19'd8,0};
    tv[13] = '{0,0,8'h00,0,2'd0,19'd0,8'h00,0, 1,0,0,0,8'h00,0,19'd9,0};
    tv[14] = '{0,0,8'h00,1,2'd0,19'd0,8'h00,0, 1,0,0,1,8'h5A,0,19'd9,0};
    tv[15] = '{0,0,8'h00,0,2'd0,19'd0,8'h00,0, 0,1,0,0,8'h00,0,19'd0,0};
    tv[16] = '{0,0,8'h00,0,2'd2,19'd3,8'hFF,0, 0,1,0,0,8'h00,0,19'd0,0};
    tv[17] = '{0,0,8'h00,0,2'd0,19'd0,8'h00,0, 0,1,0,0,8'h00,0,19'd0,1};
    tv[18] = '{1,0,8'h00,0,2'd0,19'd0,8'h00,0, 0,1,0,0,8'h00,0,19'd0,1};
    tv[19] = '{0,0,8'h00,0,2'd0,19'd0,8'h00,0, 1,0,0,0,8'h00,0,19'd0,0};
    @(negedge clk);
    #2;
    chk("reset busy", busy, 0);
    chk("reset tx_valid", tx_valid, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset viol", proc_viol, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      host_start = tv[i].hs; rx_valid = tv[i].rv; rx_data = tv[i].rd; tx_ready = tv[i].tr;
      proc_mem = tv[i].pm; proc_addr = tv[i].pa; proc_wdata = tv[i].pw; proc_status = tv[i].ps;
      #2;
      chk($sformatf("v%0d busy", i), busy, tv[i].e_busy);
      chk($sformatf("v%0d done", i), done, tv[i].e_done);
      chk($sformatf("v%0d proc_start", i), proc_start, tv[i].e_pst);
      chk($sformatf("v%0d tx_valid", i), tx_valid, tv[i].e_txv);
      chk($sformatf("v%0d tx_data", i), tx_data, tv[i].e_txd);
      chk($sformatf("v%0d mem_we", i), mem_we, tv[i].e_we);
      chk($sformatf("v%0d mem_addr", i), mem_addr, tv[i].e_addr);
      chk($sformatf("v%0d proc_viol", i), proc_viol, tv[i].e_viol);
      if (tv[i].e_we) chk($sformatf("v%0d mem_wdata", i), mem_wdata, tv[i].rv ? tv[i].rd : tv[i].pw);
      if (i == 10) chk("proc_rdata", proc_rdata, 8'h33);
    end
    chk("mem0", mem[0], 8'h11);
    chk("mem1", mem[1], 8'h22);
    chk("mem2", mem[2], 8'h33);
    chk("mem3", mem[3], 8'h44);
    chk("mem8", mem[8], 8'hA5);
    chk("mem9", mem[9], 8'h5A);
    n0 = nwr;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      idle_in();
      rx_valid = 1; rx_data = 8'(8'h55 + 8'(b) * 8'h11);
      #2;
      chk($sformatf("gap b%0d we", b), mem_we, 1);
      chk($sformatf("gap b%0d addr", b), mem_addr, b);
      for (int g = 0; g < 3 && b < 3; g++) begin
        @(negedge clk);
        idle_in();
        if (b == 0 && g == 1) begin
          proc_mem = 2'b10; proc_addr = 19'd20; proc_wdata = 8'hEE;
        end
        #2;
        chk($sformatf("gap b%0d g%0d we", b, g), mem_we, 0);
        chk($sformatf("gap b%0d g%0d start", b, g), proc_start, 0);
      end
    end
    @(negedge clk);
    idle_in();
    #2;
    chk("gap writes", nwr - n0, 4);
    chk("gap proc_start", proc_start, 1);
    chk("gap viol", proc_viol, 1);
    chk("gap mem0", mem[0], 8'h55);
    chk("gap mem1", mem[1], 8'h66);
    chk("gap mem2", mem[2], 8'h77);
    chk("gap mem3", mem[3], 8'h88);
    @(negedge clk);
    proc_mem = 2'b10; proc_addr = 19'd8; proc_wdata = 8'hC3;
    #2;
    chk("run we", mem_we, 1);
    @(negedge clk);
    proc_addr = 19'd9; proc_wdata = 8'h3C;
    @(negedge clk);
    idle_in();
    proc_status = 1;
    @(negedge clk);
    idle_in();
    #2;
    chk("rd addr", mem_addr, 8);
    chk("rd tx_valid", tx_valid, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #2;
      chk($sformatf("stall%0d tx_valid", k), tx_valid, 1);
      chk($sformatf("stall%0d tx_data", k), tx_data, 8'hC3);
      chk($sformatf("stall%0d addr", k), mem_addr, 8);
    end
    @(negedge clk);
    tx_ready = 1;
    #2;
    chk("stall release tx_data", tx_data, 8'hC3);
    @(negedge clk);
    tx_ready = 0;
    #2;
    chk("rd2 addr", mem_addr, 9);
    @(negedge clk);
    #2;
    chk("tx2 tx_data", tx_data, 8'h3C);
    chk("tx2 viol held", proc_viol, 1);
    chk("tx2 busy", busy, 1);
    #1 rst_n = 0;
    #1;
    chk("abort tx_valid", tx_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort addr", mem_addr, 0);
    chk("abort done", done, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    host_start = 1;
    @(negedge clk);
    host_start = 0; rx_valid = 1; rx_data = 8'h99;
    #2;
    chk("reload we", mem_we, 1);
    chk("reload addr", mem_addr, 0);
    chk("reload busy", busy, 1);
    @(negedge clk);
    rx_valid = 0;
    #2;
    chk("reload mem0", mem[0], 8'h99);
    chk("reload addr next", mem_addr, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
